// File: rtl/mips_instr_loader.sv
// Instruction-side front end for mips_cpu_harvard: streams a program into RAM, sequences CPU reset, serves fetches.
// Optional feature: define LOADER_CHECKSUM_EN to add a running 32-bit sum of accepted words on `checksum`.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset, CPU held in reset, waiting for init_mem
// LOAD    | accepting program words into RAM, CPU held in reset
// RELEASE | one cycle with CPU reset asserted and clock enabled
// RUN     | CPU executing, fetches served from RAM
// HALT    | CPU has dropped active, clock gated, results observable
module mips_instr_loader #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_mem,
    input  logic              init_valid,
    output logic              init_ready,
    input  logic [31:0]       init_instr,
    input  logic              init_last,
    output logic [31:0]       init_mem_addr,
    output logic [ADDR_W:0]   load_count,
    output logic              cpu_reset,
    output logic              cpu_clk_enable,
    input  logic              cpu_active,
    input  logic [31:0]       instr_address,
    output logic [31:0]       instr_readdata,
    output logic              done,
    output logic              error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_HALT
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    state_t      state;
    logic [31:0] mem [2**ADDR_W];
    logic        active_q;
    logic        active_qq;
    logic        accept;
    logic [29:0] fetch_word;
    logic        fetch_aligned;
    logic        fetch_in_ram;
    logic        fetch_hit;

    // A restart on the same edge as a beat wins, so the beat is dropped.
    assign accept = init_valid & init_ready & ~init_mem;

    // RESET_VECTOR is word aligned, so subtracting word addresses equals (addr - vector) >> 2.
    assign fetch_word    = instr_address[31:2] - RESET_VECTOR[31:2];
    assign fetch_aligned = (instr_address[1:0] == 2'b00);
    assign fetch_in_ram  = ~|fetch_word[29:ADDR_W];
    assign fetch_hit     = fetch_aligned && fetch_in_ram
                           && ({1'b0, fetch_word[ADDR_W-1:0]} < load_count);

    assign instr_readdata = fetch_hit ? mem[fetch_word[ADDR_W-1:0]] : 32'h0;
    assign init_mem_addr  = RESET_VECTOR + 32'({load_count, 2'b00});

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[load_count[ADDR_W-1:0]] <= init_instr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            load_count     <= '0;
            init_ready     <= 1'b0;
            cpu_reset      <= 1'b1;
            cpu_clk_enable <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            active_q       <= 1'b0;
            active_qq      <= 1'b0;
        end else begin
            active_q  <= cpu_active;
            active_qq <= active_q;
            if (init_mem) begin
                state          <= S_LOAD;
                load_count     <= '0;
                init_ready     <= 1'b1;
                cpu_reset      <= 1'b1;
                cpu_clk_enable <= 1'b0;
                done           <= 1'b0;
                error          <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_LOAD: begin
                        if (accept) begin
                            load_count <= load_count + 1'b1;
                            if (init_last || (load_count == LAST_IDX)) begin
                                state          <= S_RELEASE;
                                init_ready     <= 1'b0;
                                cpu_clk_enable <= 1'b1;
                                if (!init_last) begin
                                    error <= 1'b1;
                                end
                            end
                        end
                    end
                    S_RELEASE: begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                    end
                    S_RUN: begin
                        if (!fetch_aligned || !fetch_in_ram) begin
                            error <= 1'b1;
                        end
                        if (active_qq && !active_q) begin
                            state          <= S_HALT;
                            cpu_clk_enable <= 1'b0;
                            done           <= 1'b1;
                        end
                    end
                    S_HALT: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum <= '0;
        end else if (init_mem) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + init_instr;
        end
    end
`endif

endmodule

// File: doc/mips_instr_loader.md
# mips_instr_loader

Instruction-side front end for `mips_cpu_harvard`. It accepts a program as a stream of 32-bit words over a valid/ready port and stores it in an internal instruction RAM. It holds the CPU in reset while loading, then releases it and serves `instr_readdata` combinationally from `instr_address`. It also detects CPU halt, which lets directed benches (ALU, SLT, load/store) run real programs instead of driving `instr_readdata` by hand.

## Interface
- `ADDR_W`, 8, word-index width; RAM depth = 2^ADDR_W words
- `RESET_VECTOR`, 32'hBFC00000, byte address mapped to RAM word 0
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `init_mem`  in  1  start or restart a load session (sampled high for one cycle)
- `init_valid`  in  1  `init_instr` valid
- `init_ready`  out  1  loader accepts a word this cycle
- `init_instr`  in  32  program word
- `init_last`  in  1  marks the final word of the program
- `init_mem_addr`  out  32  byte address the next accepted word will occupy
- `load_count`  out  ADDR_W+1  number of words written this session
- `cpu_reset`  out  1  active-high, to CPU `reset`
- `cpu_clk_enable`  out  1  to CPU `clk_enable`
- `cpu_active`  in  1  from CPU `active`
- `instr_address`  in  32  CPU fetch byte address
- `instr_readdata`  out  32  fetched word (combinational)
- `done`  out  1  CPU has halted
- `error`  out  1  sticky: load overflow or bad fetch

## Operation
- FSM states: IDLE, LOAD, RELEASE, RUN, HALT. Reset enters IDLE.
- IDLE:
  - `cpu_reset`=1, `cpu_clk_enable`=0, `init_ready`=0.
  - `init_mem` moves to LOAD and clears `load_count`.
- LOAD:
  - `init_ready`=1, `cpu_reset`=1.
  - Each cycle with `init_valid`&`init_ready`: write `init_instr` to RAM[`load_count`], then increment `load_count`.
  - The accept beat with `init_last`=1 moves to RELEASE.
  - A write to index 2^ADDR_W−1 without `init_last` also moves to RELEASE and sets `error`.
- RELEASE: exactly one cycle with `cpu_reset`=1 and `cpu_clk_enable`=1, so the synchronous CPU reset is clocked. Then go to RUN.
- RUN:
  - `cpu_reset`=0, `cpu_clk_enable`=1.
  - A 1→0 transition of registered `cpu_active` moves to HALT.
- HALT:
  - `cpu_clk_enable`=0, `cpu_reset`=0 (`register_v0` stays observable), `done`=1.
- `init_mem` in LOAD, RELEASE, RUN or HALT restarts LOAD:
  - `load_count` cleared, `cpu_reset`=1 from the next cycle.
  - `done` and `error` are cleared.
- Fetch decode:
  - Index = (`instr_address` − `RESET_VECTOR`) >> 2, 32-bit modular subtract.
  - `instr_readdata` = RAM[index] when `instr_address[1:0]`=0 and index < `load_count`; otherwise 32'h0 (NOP).
  - In RUN, a misaligned fetch, or an index ≥ 2^ADDR_W, sets `error`.
  - A fetch with index inside the RAM but ≥ `load_count` returns NOP without error.
- `init_mem_addr` = `RESET_VECTOR` + 4·`load_count`.

## Timing
- Reset values of outputs:
  - `cpu_reset`=1
  - `cpu_clk_enable`=0
  - `init_ready`=0
  - `load_count`=0
  - `init_mem_addr`=`RESET_VECTOR`
  - `done`=0
  - `error`=0
  - `instr_readdata`=0
- RAM contents are not reset; validity is gated by `load_count`.
- Write latency is 1 cycle: a word accepted at edge N is readable combinationally after edge N.
- `init_ready` is a registered state decode. A beat is accepted only on an edge where both `init_valid` and `init_ready` are high.
- CPU first sees `cpu_reset`=0 two edges after the last accept: one edge into RELEASE, one edge into RUN.
- `done` rises one edge after the registered `cpu_active` falls, which is two edges after the CPU drops `active`.
- `init_mem` and an accept on the same edge: the restart wins and the beat is dropped.
- An asynchronous `reset` mid-load aborts the session and returns to IDLE.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - Adds output `checksum` [31:0], the modular 32-bit sum of all words accepted this session.
  - It is cleared by `reset` and by `init_mem`.
  - It updates on the same edge as the write.
- `LOADER_CHECKSUM_EN` undefined: no `checksum` port and no adder. All other behaviour is identical.

## Test plan
- Load 3 words {8C020000, 0022182A, 24620000, last}, CPU stubbed with `active`=1 → `load_count`=3, `init_mem_addr`=BFC0000C, `cpu_reset` low 2 edges after the last accept.
- After that load, `instr_address`=BFC00004 → `instr_readdata`=0022182A. `instr_address`=BFC0000C → 0 with `error`=0.
- `init_valid` toggled every other cycle while loading 5 words → no beat lost or duplicated; RAM[0..4] match the input order.
- `ADDR_W`=2, 4 words sent without `init_last` → transition to RELEASE after the 4th word, `error`=1, `load_count`=4.
- In RUN, drop `cpu_active` → `done`=1 two edges later, `cpu_clk_enable`=0. Then `init_mem` → `done`=0, `cpu_reset`=1, `load_count`=0.
- With `LOADER_CHECKSUM_EN`: load FFFFFFFF, 00000002 → `checksum`=00000001.
